// File: rtl/tug_match_ctrl.sv
// tug_match_ctrl: match-level sequencer for the two-player tug-of-war game.
// Latency: start in IDLE -> CLEAR at +1, PLAY at +2; a round win scores on the edge it is seen.
// Backpressure: none; start is honoured only in IDLE/DONE, win flags only in PLAY.
//
// Ports:
//   Clock, reset      - system clock, asynchronous active-high reset
//   start             - begin a match from IDLE or DONE
//   win1, win2        - sticky round-win flags from the win detector
//   play_reset        - registered; clears playfield + win detector (IDLE/CLEAR/DONE)
//   in_play           - registered; high while a round is live (PLAY)
//   score1, score2    - saturating round-win counters
//   match_over        - registered; high in DONE
//   winner1, winner2  - match winner flags, valid in DONE
//
// Build option: define TUG_MATCH_DEUCE_EN to require a two-round lead to take the
// match (with saturation ending the match for the leader, or as a tie).
module tug_match_ctrl #(
  parameter int WINS_TO_MATCH = 3,
  parameter int HOLD_CYCLES   = 4,
  parameter int SCORE_W       = 4
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               start,
  input  logic               win1,
  input  logic               win2,
  output logic               play_reset,
  output logic               in_play,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               match_over,
  output logic               winner1,
  output logic               winner2
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PLAY,
    S_HOLD,
    S_DONE
  } state_t;

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t            state, state_nxt;
  logic [HC_W-1:0]   hold_cnt, hold_cnt_nxt;
  logic [SCORE_W-1:0] score1_nxt, score2_nxt;
  logic              winner1_nxt, winner2_nxt;
  logic              p1_takes, p2_takes, tie_end;

  // Match-end decision, evaluated on the scores already updated for this round.
`ifdef TUG_MATCH_DEUCE_EN
  logic [SCORE_W:0] s1x, s2x, target;
  always_comb begin
    s1x    = {1'b0, score1};
    s2x    = {1'b0, score2};
    target = (SCORE_W+1)'(WINS_TO_MATCH);
    // One extra bit keeps the +2 lead comparison from wrapping near saturation.
    p1_takes = ((s1x >= target) && (s1x >= s2x + (SCORE_W+1)'(2))) ||
               ((score1 == SCORE_MAX) && (score1 > score2));
    p2_takes = ((s2x >= target) && (s2x >= s1x + (SCORE_W+1)'(2))) ||
               ((score2 == SCORE_MAX) && (score2 > score1));
    tie_end  = (score1 == SCORE_MAX) && (score2 == SCORE_MAX);
  end
`else
  always_comb begin
    p1_takes = (score1 == SCORE_W'(WINS_TO_MATCH));
    p2_takes = (score2 == SCORE_W'(WINS_TO_MATCH));
    tie_end  = 1'b0;
  end
`endif

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    score1_nxt   = score1;
    score2_nxt   = score2;
    winner1_nxt  = winner1;
    winner2_nxt  = winner2;

    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // A tie still ends the round (replayed) but scores nobody.
        if (win1 || win2) begin
          state_nxt    = S_HOLD;
          hold_cnt_nxt = '0;
          if (win1 && !win2 && (score1 != SCORE_MAX)) score1_nxt = score1 + 1'b1;
          if (win2 && !win1 && (score2 != SCORE_MAX)) score2_nxt = score2 + 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          if (p1_takes) begin
            state_nxt   = S_DONE;
            winner1_nxt = 1'b1;
          end else if (p2_takes) begin
            state_nxt   = S_DONE;
            winner2_nxt = 1'b1;
          end else if (tie_end) begin
            state_nxt   = S_DONE;
          end else begin
            state_nxt   = S_CLEAR;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_nxt   = S_CLEAR;
          score1_nxt  = '0;
          score2_nxt  = '0;
          winner1_nxt = 1'b0;
          winner2_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge Clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold_cnt   <= '0;
      score1     <= '0;
      score2     <= '0;
      winner1    <= 1'b0;
      winner2    <= 1'b0;
      play_reset <= 1'b1;
      in_play    <= 1'b0;
      match_over <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_cnt_nxt;
      score1     <= score1_nxt;
      score2     <= score2_nxt;
      winner1    <= winner1_nxt;
      winner2    <= winner2_nxt;
      play_reset <= (state_nxt == S_IDLE) || (state_nxt == S_CLEAR) || (state_nxt == S_DONE);
      in_play    <= (state_nxt == S_PLAY);
      match_over <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_tug_match_ctrl.sv
// tb_tug_match_ctrl: directed bench for tug_match_ctrl in its default (first-to-target) build.
// Latency: samples 1 time unit after each rising Clock edge.
// Backpressure: none.
module tb_tug_match_ctrl;

  logic       Clock = 1'b0;
  logic       reset;
  logic       start;
  logic       win1;
  logic       win2;
  logic       play_reset;
  logic       in_play;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       match_over;
  logic       winner1;
  logic       winner2;

  int checks = 0;
  int errors = 0;

  tug_match_ctrl #(
    .WINS_TO_MATCH(3),
    .HOLD_CYCLES  (4),
    .SCORE_W      (4)
  ) dut (
    .Clock     (Clock),
    .reset     (reset),
    .start     (start),
    .win1      (win1),
    .win2      (win2),
    .play_reset(play_reset),
    .in_play   (in_play),
    .score1    (score1),
    .score2    (score2),
    .match_over(match_over),
    .winner1   (winner1),
    .winner2   (winner2)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a round result in PLAY, walk through the 4 HOLD cycles, then take
  // one more edge so the caller sees the state that follows HOLD.
  task automatic round(input logic w1, input logic w2);
    win1 = w1;
    win2 = w2;
    tick();
    chk("hold_in_play", {31'd0, in_play}, 32'd0);
    chk("hold_play_reset", {31'd0, play_reset}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_keep", {31'd0, play_reset}, 32'd0);
    end
    win1 = 1'b0;
    win2 = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    win1  = 1'b0;
    win2  = 1'b0;
    #12;
    chk("rst_play_reset", {31'd0, play_reset}, 32'd1);
    chk("rst_in_play", {31'd0, in_play}, 32'd0);
    chk("rst_scores", {24'd0, score1, score2}, 32'd0);
    chk("rst_done", {29'd0, match_over, winner1, winner2}, 32'd0);
    reset = 1'b0;

    // Idle holds without start.
    tick();
    chk("idle_hold", {30'd0, play_reset, in_play}, 32'h2);

    // Start: CLEAR at +1, PLAY at +2.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("clear_state", {30'd0, play_reset, in_play}, 32'h2);
    tick();
    chk("play_state", {30'd0, play_reset, in_play}, 32'h1);
    tick();
    chk("play_stay", {30'd0, play_reset, in_play}, 32'h1);

    // Player 1 round: score visible one cycle after win1.
    win1 = 1'b1;
    tick();
    chk("p1_score", {24'd0, score1, score2}, 32'h10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("p1_hold", {30'd0, play_reset, in_play}, 32'h0);
    end
    tick();
    win1 = 1'b0;
    chk("p1_clear", {30'd0, play_reset, in_play}, 32'h2);
    tick();
    chk("p1_play", {30'd0, play_reset, in_play}, 32'h1);

    // Tie: replay, scores unchanged.
    round(1'b1, 1'b1);
    chk("tie_clear", {30'd0, play_reset, in_play}, 32'h2);
    chk("tie_scores", {24'd0, score1, score2}, 32'h10);
    tick();
    chk("tie_play", {31'd0, in_play}, 32'd1);

    // Player 2 takes three rounds.
    round(1'b0, 1'b1);
    chk("p2_r1", {24'd0, score1, score2}, 32'h11);
    chk("p2_r1_clear", {30'd0, play_reset, in_play}, 32'h2);
    tick();
    round(1'b0, 1'b1);
    chk("p2_r2", {24'd0, score1, score2}, 32'h12);
    tick();
    round(1'b0, 1'b1);
    chk("p2_done_scores", {24'd0, score1, score2}, 32'h13);
    chk("p2_done_flags", {29'd0, match_over, winner1, winner2}, 32'h5);
    chk("p2_done_outs", {30'd0, play_reset, in_play}, 32'h2);

    // DONE holds and ignores win flags.
    win1 = 1'b1;
    tick();
    tick();
    win1 = 1'b0;
    chk("done_hold", {21'd0, match_over, winner1, winner2, score1, score2}, 32'h513);

    // Restart with start held high: clears on DONE exit, ignored afterwards.
    start = 1'b1;
    tick();
    chk("restart_clear", {22'd0, play_reset, in_play, score1, score2}, 32'h200);
    chk("restart_flags", {29'd0, match_over, winner1, winner2}, 32'd0);
    tick();
    chk("restart_play", {30'd0, play_reset, in_play}, 32'h1);
    tick();
    chk("start_ignored_play", {30'd0, play_reset, in_play}, 32'h1);
    start = 1'b0;

    // Reach score1=2 then reset asynchronously in the middle of HOLD.
    round(1'b1, 1'b0);
    tick();
    win1 = 1'b1;
    tick();
    chk("pre_reset_score", {24'd0, score1, score2}, 32'h20);
    tick();
    win1 = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_scores", {24'd0, score1, score2}, 32'd0);
    chk("async_rst_outs", {30'd0, play_reset, in_play}, 32'h2);
    chk("async_rst_flags", {29'd0, match_over, winner1, winner2}, 32'd0);
    #2;
    reset = 1'b0;

    // Back in IDLE: a fresh start works.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_play", {30'd0, play_reset, in_play}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
